reg_file_2w2r_sb: RTL
=====================

REG_FILE_2W2R_SB -- requirements
Module: reg_file_2w2r_sb

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 16, giving the register width in bits.
REQ-002 The block SHALL have the parameter ADDR_W, default 3, giving the address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have the parameter ZERO_REG, default 0; when set to 1, register 0 always reads 0 and is never busy.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have the ports wr0_en, wr1_en, input, 1 bit each: write enable of write port 0 and write port 1.
REQ-007 The block SHALL have the ports wr0_addr, wr1_addr, input, ADDR_W bits each: write address of each write port.
REQ-008 The block SHALL have the ports wr0_data, wr1_data, input, DATA_W bits each: write data of each write port.
REQ-009 The block SHALL have the ports rd0_addr, rd1_addr, input, ADDR_W bits each: read address of each read port.
REQ-010 The block SHALL have the ports rd0_data, rd1_data, output, DATA_W bits each: read data of each read port.
REQ-011 The block SHALL have the port busy_set_en, input, 1 bit: marks a register as pending a write-back.
REQ-012 The block SHALL have the port busy_set_addr, input, ADDR_W bits: the register to mark pending.
REQ-013 The block SHALL have the ports rd0_busy, rd1_busy, output, 1 bit each: the pending flag of the register addressed by rd0_addr and rd1_addr.

Function
REQ-014 Reads SHALL be combinational from the current rd*_addr, with zero-cycle latency.
REQ-015 A write with wr*_en=1 SHALL update the addressed register at the next rising clk edge and be visible on the read ports from the following cycle.
REQ-016 When both write ports are enabled and target the same address in one cycle, the register SHALL take wr1_data (port 1 wins).
REQ-017 When the write ports target different addresses in one cycle, both writes SHALL complete in that cycle.
REQ-018 Each register SHALL have a busy bit; busy_set_en=1 SHALL set the bit for busy_set_addr at the next edge.
REQ-019 A write from either port SHALL clear the busy bit of its address at the next edge.
REQ-020 When a set and a clear hit the same address in one cycle, the set SHALL win and the bit SHALL end the cycle at 1.
REQ-021 Setting an already-busy register SHALL leave its bit at 1; writing a non-busy register SHALL leave its bit at 0.
REQ-022 With ZERO_REG=1, writes and busy sets to address 0 SHALL be ignored, and rd*_data=0 and rd*_busy=0 SHALL hold whenever rd*_addr=0.
REQ-023 Both read ports SHALL be able to address the same register in one cycle, and both SHALL return identical data and busy values.

Reset
REQ-024 While rst_n=0 at a rising edge, all registers SHALL be cleared to 0 and all busy bits SHALL be cleared to 0.
REQ-025 Writes and busy sets presented during reset SHALL be discarded, and a reset asserted mid-sequence SHALL override any same-cycle write or set.
REQ-026 After reset, rd*_data SHALL read 0 and rd*_busy SHALL read 0 for every address.

Configuration
REQ-027 With the macro REGFILE_BYPASS_EN defined, a read of an address being written in the same cycle SHALL return the incoming write data combinationally, with port 1 taking priority over port 0.
REQ-028 With REGFILE_BYPASS_EN defined, rd*_busy SHALL read 0 for an address being written in the same cycle, unless busy_set_en targets that same address in that cycle.
REQ-029 Without REGFILE_BYPASS_EN, rd*_data and rd*_busy SHALL reflect stored state only, so that a write becomes visible one cycle later.
REQ-030 Bypass SHALL never apply during reset or to address 0 when ZERO_REG=1.

Structure
REQ-031 The shared package regfile_pkg SHALL hold the default DATA_W and ADDR_W constants and a DEPTH-from-ADDR_W function.
REQ-032 The busy-bit array and its set/clear priority logic SHALL be a sub-module named reg_scoreboard, instantiated once.

Verification
REQ-033 The bench SHALL check: reset, then read all 8 addresses -> every rd*_data=0 and every rd*_busy=0.
REQ-034 The bench SHALL check: wr0 addr 3 data 0x1234 and wr1 addr 5 data 0xBEEF in the same cycle -> next cycle rd0(3)=0x1234 and rd1(5)=0xBEEF.
REQ-035 The bench SHALL check: wr0 and wr1 both to addr 2 with data 0x1111 and 0x2222 -> rd0(2)=0x2222.
REQ-036 The bench SHALL check: busy_set addr 4, then rd0_busy(4)=1; wr0 to addr 4 with a same-cycle busy_set on addr 4 -> rd0_busy(4)=1; a later wr0 to addr 4 -> rd0_busy(4)=0.
REQ-037 The bench SHALL check: with REGFILE_BYPASS_EN, wr1 addr 6 data 0xA5A5 while rd1_addr=6 -> rd1_data=0xA5A5 in the same cycle; without the macro -> the old value in that cycle and 0xA5A5 in the next.
REQ-038 The bench SHALL check: with ZERO_REG=1, wr0 addr 0 data 0xFFFF plus busy_set on addr 0 -> rd0(0)=0 and rd0_busy=0; and an assertion of rst_n=0 mid-sequence -> all registers read 0 on the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizing constants and helpers for the 2W2R register file
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 3;

    // Number of registers addressable with addr_w address bits.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // True when addr selects the hard-wired zero register of a ZERO_REG build.
    function automatic bit is_zero_reg(input bit zero_reg_en, input logic [31:0] addr);
        return zero_reg_en && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending write-back flags with set-over-clear priority
//   clk, rst_n            : clock, synchronous active-low reset
//   set_en, set_addr      : mark a register pending at the next edge
//   clr0_en/clr0_addr,
//   clr1_en/clr1_addr     : write-back completions clearing the flag at the next edge
//   busy                  : current flag vector, one bit per register
module reg_scoreboard #(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr0_en,
    input  logic [ADDR_W-1:0] clr0_addr,
    input  logic              clr1_en,
    input  logic [ADDR_W-1:0] clr1_addr,
    output logic [DEPTH-1:0]  busy
);

    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;
    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) begin
            set_mask[set_addr] = 1'b1;
        end
        if (clr0_en) begin
            clr_mask[clr0_addr] = 1'b1;
        end
        if (clr1_en) begin
            clr_mask[clr1_addr] = 1'b1;
        end
        // Clear first, then OR in the set: an issue that re-targets a register
        // whose previous result lands this cycle must stay pending.
        busy_nxt = (busy & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/reg_file_2w2r_sb.sv
// rtl/reg_file_2w2r_sb.sv - two-write two-read register file with per-register busy scoreboard
//   Optional macro REGFILE_BYPASS_EN: same-cycle write data / busy state forwarded to reads.
//   clk, rst_n                  : clock, synchronous active-low reset
//   wr0_*/wr1_* (en,addr,data)  : write ports, port 1 wins on an address collision
//   rd0_addr/rd1_addr           : combinational read addresses
//   rd0_data/rd1_data           : read data
//   busy_set_en/busy_set_addr   : mark a register pending a write-back
//   rd0_busy/rd1_busy           : pending flag of the register being read
module reg_file_2w2r_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              busy_set_en,
    input  logic [ADDR_W-1:0] busy_set_addr,
    output logic              rd0_busy,
    output logic              rd1_busy
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;

    // Enables with accesses to the hard-wired zero register removed, so that
    // neither storage nor scoreboard ever changes for address 0 in a ZR build.
    logic wr0_ok;
    logic wr1_ok;
    logic set_ok;

    assign wr0_ok = wr0_en      && !is_zero_reg(ZR, 32'(wr0_addr));
    assign wr1_ok = wr1_en      && !is_zero_reg(ZR, 32'(wr1_addr));
    assign set_ok = busy_set_en && !is_zero_reg(ZR, 32'(busy_set_addr));

    // Port 1 is applied after port 0 so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                mem[wr0_addr] <= wr0_data;
            end
            if (wr1_ok) begin
                mem[wr1_addr] <= wr1_data;
            end
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (set_ok),
        .set_addr  (busy_set_addr),
        .clr0_en   (wr0_ok),
        .clr0_addr (wr0_addr),
        .clr1_en   (wr1_ok),
        .clr1_addr (wr1_addr),
        .busy      (busy_q)
    );

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    assign rd_addr[0] = rd0_addr;
    assign rd_addr[1] = rd1_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = mem[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            // Forward the value the register will hold after this edge. The
            // wr*_ok terms already exclude the zero register; rst_n gates out
            // forwarding while a reset is discarding the write.
            if (rst_n && ((wr0_ok && (wr0_addr == rd_addr[p])) ||
                          (wr1_ok && (wr1_addr == rd_addr[p])))) begin
                rd_data[p] = (wr1_ok && (wr1_addr == rd_addr[p])) ? wr1_data : wr0_data;
                rd_busy[p] = set_ok && (busy_set_addr == rd_addr[p]);
            end
`endif
            if (is_zero_reg(ZR, 32'(rd_addr[p]))) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign rd0_data = rd_data[0];
    assign rd1_data = rd_data[1];
    assign rd0_busy = rd_busy[0];
    assign rd1_busy = rd_busy[1];

endmodule
